// File: rtl/sb_msg_pkg.sv
// Shared sideband message definitions: the message enum, the {code, subcode}
// header struct, and encode/decode/response-pairing helpers.
package sb_msg_pkg;

  typedef enum logic [3:0] {
    SBINIT_out_of_reset   = 4'd0,
    SBINIT_done_req       = 4'd1,
    SBINIT_done_resp      = 4'd2,
    MBINIT_PARAM_cfg_req  = 4'd3,
    MBINIT_PARAM_cfg_resp = 4'd4,
    CODEX_ERROR           = 4'hF
  } sb_msg_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] subcode;
  } sb_hdr_t;

  localparam sb_hdr_t SB_HDR_NONE = '{code: 8'hFF, subcode: 8'hFF};

  // Message number to wire header; FF/FF marks "no encoding".
  function automatic sb_hdr_t encode_sb_msg(input sb_msg_t msg);
    sb_hdr_t hdr;
    case (msg)
      SBINIT_out_of_reset:   hdr = '{code: 8'h91, subcode: 8'h00};
      SBINIT_done_req:       hdr = '{code: 8'h95, subcode: 8'h01};
      SBINIT_done_resp:      hdr = '{code: 8'h9A, subcode: 8'h01};
      MBINIT_PARAM_cfg_req:  hdr = '{code: 8'hA5, subcode: 8'h00};
      MBINIT_PARAM_cfg_resp: hdr = '{code: 8'hAA, subcode: 8'h00};
      default:               hdr = SB_HDR_NONE;
    endcase
    return hdr;
  endfunction

  // Wire header to message number; CODEX_ERROR for unknown headers.
  function automatic sb_msg_t decode_sb_msg(input logic [7:0] code, input logic [7:0] subcode);
    sb_msg_t msg;
    case ({code, subcode})
      16'h9100: msg = SBINIT_out_of_reset;
      16'h9501: msg = SBINIT_done_req;
      16'h9A01: msg = SBINIT_done_resp;
      16'hA500: msg = MBINIT_PARAM_cfg_req;
      16'hAA00: msg = MBINIT_PARAM_cfg_resp;
      default:  msg = CODEX_ERROR;
    endcase
    return msg;
  endfunction

  // Response paired with a request; CODEX_ERROR when the message is not a request.
  function automatic sb_msg_t resp_of(input sb_msg_t req);
    sb_msg_t resp;
    case (req)
      SBINIT_done_req:      resp = SBINIT_done_resp;
      MBINIT_PARAM_cfg_req: resp = MBINIT_PARAM_cfg_resp;
      default:              resp = CODEX_ERROR;
    endcase
    return resp;
  endfunction

endpackage

// File: rtl/sb_msg_rx_decoder.sv
// Inbound sideband beat decoder. Registers the decoded message one cycle after
// the beat, flags rejected beats on decode_err, and exposes the same-cycle
// accept/decode (_c) so the engine can complete a transaction on that edge.
// Optional macro SB_PARITY_EN: enables the even-parity check on inbound beats.
// Ports: sb_rx_* inbound beat; beat_ok_c/beat_msg_c combinational decode;
//        rx_msg_valid/rx_msg/rx_msg_data/decode_err registered results.
module sb_msg_rx_decoder import sb_msg_pkg::*; #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sb_rx_valid,
  input  logic [7:0]        sb_rx_code,
  input  logic [7:0]        sb_rx_subcode,
  input  logic [DATA_W-1:0] sb_rx_data,
  input  logic              sb_rx_parity,
  output logic              beat_ok_c,
  output sb_msg_t           beat_msg_c,
  output logic              rx_msg_valid,
  output sb_msg_t           rx_msg,
  output logic [DATA_W-1:0] rx_msg_data,
  output logic              decode_err
);

  logic parity_ok;

`ifdef SB_PARITY_EN
  assign parity_ok = ((^{sb_rx_code, sb_rx_subcode, sb_rx_data}) == sb_rx_parity);
`else
  logic unused_parity;
  assign unused_parity = sb_rx_parity;
  assign parity_ok     = 1'b1;
`endif

  // Same-cycle decode of the inbound beat.
  always_comb begin
    beat_msg_c = decode_sb_msg(sb_rx_code, sb_rx_subcode);
    beat_ok_c  = sb_rx_valid && parity_ok && (beat_msg_c != CODEX_ERROR);
  end

  // Registered decode results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_msg_valid <= 1'b0;
      rx_msg       <= SBINIT_out_of_reset;
      rx_msg_data  <= '0;
      decode_err   <= 1'b0;
    end else begin
      rx_msg_valid <= beat_ok_c;
      decode_err   <= sb_rx_valid && !beat_ok_c;
      if (beat_ok_c) begin
        rx_msg      <= beat_msg_c;
        rx_msg_data <= sb_rx_data;
      end
    end
  end

endmodule

// File: rtl/sb_msg_engine.sv
// Sideband message engine: encodes LTSM requests into outbound beats, decodes
// inbound beats, and tracks request/response transactions with a per-attempt
// timeout and a bounded number of re-sends.
// Optional macro SB_PARITY_EN: drives even parity on sb_tx_parity and checks
// sb_rx_parity; without it sb_tx_parity is 0 and sb_rx_parity is ignored.
// Ports: tx_req_* LTSM request side; sb_tx_* outbound link; sb_rx_* inbound
//        link; rx_msg_* decoded messages; txn_done/txn_timeout/enc_err/
//        decode_err single-cycle status pulses.
module sb_msg_engine import sb_msg_pkg::*; #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 8000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_req_valid,
  output logic              tx_req_ready,
  input  sb_msg_t           tx_req_msg,
  input  logic [DATA_W-1:0] tx_req_data,
  input  logic              tx_expect_resp,
  output logic              sb_tx_valid,
  input  logic              sb_tx_ready,
  output logic [7:0]        sb_tx_code,
  output logic [7:0]        sb_tx_subcode,
  output logic [DATA_W-1:0] sb_tx_data,
  output logic              sb_tx_parity,
  input  logic              sb_rx_valid,
  input  logic [7:0]        sb_rx_code,
  input  logic [7:0]        sb_rx_subcode,
  input  logic [DATA_W-1:0] sb_rx_data,
  input  logic              sb_rx_parity,
  output logic              rx_msg_valid,
  output sb_msg_t           rx_msg,
  output logic [DATA_W-1:0] rx_msg_data,
  output logic              txn_done,
  output logic              txn_timeout,
  output logic              enc_err,
  output logic              decode_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_RESP} state_t;

  state_t             state_q, state_d;
  sb_msg_t            msg_q, msg_d;
  sb_hdr_t            hdr_q, hdr_d, req_hdr;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               expect_q, expect_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               done_d, timeout_d, enc_err_d;
  logic               beat_ok_c, resp_match;
  sb_msg_t            beat_msg_c;

  sb_msg_rx_decoder #(.DATA_W(DATA_W)) u_rx_dec (
    .clk          (clk),
    .rst_n        (rst_n),
    .sb_rx_valid  (sb_rx_valid),
    .sb_rx_code   (sb_rx_code),
    .sb_rx_subcode(sb_rx_subcode),
    .sb_rx_data   (sb_rx_data),
    .sb_rx_parity (sb_rx_parity),
    .beat_ok_c    (beat_ok_c),
    .beat_msg_c   (beat_msg_c),
    .rx_msg_valid (rx_msg_valid),
    .rx_msg       (rx_msg),
    .rx_msg_data  (rx_msg_data),
    .decode_err   (decode_err)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    expect_d   = expect_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    enc_err_d  = 1'b0;
    req_hdr    = encode_sb_msg(tx_req_msg);
    // Decode is the same one the rx path registers, so txn_done lines up with rx_msg_valid.
    resp_match = beat_ok_c && (beat_msg_c == resp_of(msg_q));

    case (state_q)
      ST_IDLE: begin
        if (tx_req_valid) begin
          msg_d    = tx_req_msg;
          hdr_d    = req_hdr;
          data_d   = tx_req_data;
          expect_d = tx_expect_resp;
          retry_d  = '0;
          if (req_hdr == SB_HDR_NONE) enc_err_d = 1'b1;
          else                        state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sb_tx_ready) begin
          if (expect_q) begin
            state_d = ST_WAIT_RESP;
            timer_d = '0;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_RESP: begin
        timer_d = timer_q + TMR_W'(1);
        // A match on the expiry cycle takes priority over retry/timeout.
        if (resp_match) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_SEND;
          end else begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      msg_q        <= SBINIT_out_of_reset;
      hdr_q        <= '0;
      data_q       <= '0;
      expect_q     <= 1'b0;
      timer_q      <= '0;
      retry_q      <= '0;
      tx_req_ready <= 1'b1;
      sb_tx_valid  <= 1'b0;
      txn_done     <= 1'b0;
      txn_timeout  <= 1'b0;
      enc_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      hdr_q        <= hdr_d;
      data_q       <= data_d;
      expect_q     <= expect_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      tx_req_ready <= (state_d == ST_IDLE);
      sb_tx_valid  <= (state_d == ST_SEND);
      txn_done     <= done_d;
      txn_timeout  <= timeout_d;
      enc_err      <= enc_err_d;
    end
  end

  assign sb_tx_code    = hdr_q.code;
  assign sb_tx_subcode = hdr_q.subcode;
  assign sb_tx_data    = data_q;

`ifdef SB_PARITY_EN
  // Parity tracks the latched header/payload so it is stable with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_tx_parity <= 1'b0;
    else        sb_tx_parity <= ^{hdr_d, data_d};
  end
`else
  assign sb_tx_parity = 1'b0;
`endif

endmodule
